wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the integer register file. Shares the register file's single write port among NREQ write-back sources (ALU, load unit, CSR unit), registers the winning write onto the regfile write port, and tracks in-flight destination registers so decode can stall on RAW hazards. Sits between the execute/memory stages and the register file; decode queries it alongside the regfile read ports.

---
 rtl/wb_arbiter_pkg.sv | 12 +
 rtl/wb_rr_pick.sv | 29 ++
 rtl/wb_arbiter.sv | 113 +++++++++++
 tb/tb_wb_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file widths and constants for the write-back arbiter.
package wb_arbiter_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int REG_NUM      = 32;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/wb_rr_pick.sv
// One-hot picker: first set request at or after the start pointer, wrapping.
module wb_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  int j;

  // Walk from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter plus RAW scoreboard.
// WB_ARB_RR_EN selects round-robin; otherwise fixed priority (index 0 first).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = REG_BUS,
  parameter int ADDR_W = REG_ADDR_BUS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_waddr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   hold,
  output logic                   we,
  output logic [ADDR_W-1:0]      waddr,
  output logic [DATA_W-1:0]      wdata,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_rd,
  input  logic [ADDR_W-1:0]      qry_rs1,
  input  logic [ADDR_W-1:0]      qry_rs2,
  output logic                   busy_rs1,
  output logic                   busy_rs2
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 1 << ADDR_W;

  logic [NREQ-1:0]   req_eff;
  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     start;
  logic [PW-1:0]     gidx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_waddr;
  logic [DATA_W-1:0] sel_wdata;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;

  assign req_eff = (hold || rst) ? '0 : req_valid;

`ifdef WB_ARB_RR_EN
  logic [PW-1:0] last_grant_q, last_grant_d;

  always_comb begin
    start = (last_grant_q == PW'(NREQ - 1)) ? '0
          : last_grant_q + PW'(1);
    last_grant_d = xfer ? gidx : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) last_grant_q <= PW'(NREQ - 1);
    else                   last_grant_q <= last_grant_d;
  end
`else
  assign start = '0;
`endif

  wb_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req   (req_eff),
    .start (start),
    .gnt   (gnt),
    .idx   (gidx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_waddr = req_waddr[int'(gidx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(gidx)*DATA_W +: DATA_W];

  // A granted write to x0 is consumed but never reaches the regfile.
  always_comb begin
    we_d      = xfer && (sel_waddr != '0);
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;
    if (we_d) begin
      waddr_d = sel_waddr;
      wdata_d = sel_wdata;
    end
    if (we_q) pending_d[waddr_q] = 1'b0;
    if (iss_valid && iss_rd != '0) pending_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign we    = (we_q == WRITE_ENABLE);
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  // Bypass mirrors the regfile's same-cycle write-to-read forwarding.
  assign busy_rs1 = (qry_rs1 != '0) && pending_q[qry_rs1]
                 && !(we_q && waddr_q == qry_rs1);
  assign busy_rs2 = (qry_rs2 != '0) && pending_q[qry_rs2]
                 && !(we_q && waddr_q == qry_rs2);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter (fixed or round-robin build).
module tb_wb_arbiter;

  localparam logic [31:0] WD0 = 32'h1111_0000;
  localparam logic [31:0] WD1 = 32'h2222_0001;
  localparam logic [31:0] WD2 = 32'h3333_0002;
  localparam logic [14:0] WA  = {5'd9, 5'd7, 5'd3};
  localparam logic [95:0] WD  = {WD2, WD1, WD0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_waddr = WA;
  logic [95:0] req_wdata = WD;
  logic [2:0]  req_ready;
  logic        hold = 1'b0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  qry_rs1 = '0;
  logic [4:0]  qry_rs2 = '0;
  logic        busy_rs1, busy_rs2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .hold      (hold),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .qry_rs1   (qry_rs1),
    .qry_rs2   (qry_rs2),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2)
  );

  typedef struct {
    logic [2:0]  vld;
    logic [14:0] wa;
    logic [95:0] wd;
    logic        hld;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic [2:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_b1;
    logic        e_b2;
    logic        cw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [2:0] vld, logic hld, logic iv, logic [4:0] ird,
    logic [4:0] q1, logic [4:0] q2, logic [2:0] e_rdy,
    logic e_we, logic [4:0] e_wa, logic [31:0] e_wd,
    logic e_b1, logic e_b2, logic cw);
    vec_t v;
    v.vld = vld; v.wa = WA; v.wd = WD; v.hld = hld;
    v.iv = iv; v.ird = ird; v.q1 = q1; v.q2 = q2;
    v.e_rdy = e_rdy; v.e_we = e_we; v.e_wa = e_wa;
    v.e_wd = e_wd; v.e_b1 = e_b1; v.e_b2 = e_b2; v.cw = cw;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Multi-requester expectations, per cycle.
`ifdef WB_ARB_RR_EN
  localparam int NS = 8;
  logic [2:0] s_vld[NS] = '{3'b111, 3'b111, 3'b111, 3'b111,
                            3'b111, 3'b111, 3'b111, 3'b000};
  logic       s_hld[NS] = '{0, 0, 0, 0, 1, 1, 0, 0};
  logic [2:0] s_rdy[NS] = '{3'b001, 3'b010, 3'b100, 3'b001,
                            3'b000, 3'b000, 3'b010, 3'b000};
  logic       s_we[NS]  = '{0, 1, 1, 1, 1, 0, 0, 1};
  logic [4:0] s_wa[NS]  = '{0, 3, 7, 9, 3, 3, 3, 7};
`else
  localparam int NS = 7;
  logic [2:0] s_vld[NS] = '{3'b110, 3'b110, 3'b110,
                            3'b111, 3'b111, 3'b111, 3'b000};
  logic       s_hld[NS] = '{0, 0, 0, 1, 1, 0, 0};
  logic [2:0] s_rdy[NS] = '{3'b010, 3'b010, 3'b010,
                            3'b000, 3'b000, 3'b001, 3'b000};
  logic       s_we[NS]  = '{0, 1, 1, 1, 0, 0, 1};
  logic [4:0] s_wa[NS]  = '{0, 7, 7, 7, 7, 7, 3};
`endif

  initial begin
    vec_t v;
    // vld hld iv ird q1 q2 | rdy we wa wd b1 b2 cw
    tbl.push_back(mk(3'b000, 0, 1, 7, 7, 0, 3'b000, 0, 0, 0,   0, 0, 1));
    tbl.push_back(mk(3'b010, 0, 0, 0, 7, 0, 3'b010, 0, 0, 0,   1, 0, 1));
    tbl.push_back(mk(3'b000, 0, 1, 7, 7, 7, 3'b000, 1, 7, WD1, 0, 0, 1));
    tbl.push_back(mk(3'b000, 0, 0, 0, 7, 7, 3'b000, 0, 7, WD1, 1, 1, 1));
    tbl.push_back(mk(3'b010, 0, 0, 0, 7, 0, 3'b010, 0, 7, WD1, 1, 0, 1));
    tbl.push_back(mk(3'b000, 0, 0, 0, 7, 0, 3'b000, 1, 7, WD1, 0, 0, 1));
    tbl.push_back(mk(3'b000, 0, 0, 0, 7, 7, 3'b000, 0, 7, WD1, 0, 0, 1));
    v = mk(3'b001, 0, 1, 0, 0, 0, 3'b001, 0, 7, WD1, 0, 0, 1);
    v.wa = {5'd9, 5'd7, 5'd0};
    v.wd = {WD2, WD1, 32'hDEAD_BEEF};
    tbl.push_back(v);
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 7, WD1, 0, 0, 0));
    tbl.push_back(mk(3'b100, 0, 0, 0, 0, 0, 3'b100, 0, 7, WD1, 0, 0, 0));
    tbl.push_back(mk(3'b001, 1, 0, 0, 0, 0, 3'b000, 1, 9, WD2, 0, 0, 1));
    tbl.push_back(mk(3'b001, 1, 0, 0, 0, 0, 3'b000, 0, 9, WD2, 0, 0, 1));
    tbl.push_back(mk(3'b001, 0, 0, 0, 0, 0, 3'b001, 0, 9, WD2, 0, 0, 1));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 3, WD0, 0, 0, 1));

    // Reset state
    #1;
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_we", 64'(we), 0);
    chk("rst_waddr", 64'(waddr), 0);
    chk("rst_wdata", 64'(wdata), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      req_valid = tbl[i].vld;
      req_waddr = tbl[i].wa;
      req_wdata = tbl[i].wd;
      hold      = tbl[i].hld;
      iss_valid = tbl[i].iv;
      iss_rd    = tbl[i].ird;
      qry_rs1   = tbl[i].q1;
      qry_rs2   = tbl[i].q2;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_we", i), 64'(we), 64'(tbl[i].e_we));
      chk($sformatf("v%0d_busy1", i), 64'(busy_rs1), 64'(tbl[i].e_b1));
      chk($sformatf("v%0d_busy2", i), 64'(busy_rs2), 64'(tbl[i].e_b2));
      if (tbl[i].cw) begin
        chk($sformatf("v%0d_waddr", i), 64'(waddr), 64'(tbl[i].e_wa));
        chk($sformatf("v%0d_wdata", i), 64'(wdata), 64'(tbl[i].e_wd));
      end
    end

    // Reset mid-stream with pending rd=5 and all requesters valid
    @(negedge clk);
    req_waddr = WA;
    req_wdata = WD;
    hold      = 1'b0;
    req_valid = 3'b111;
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    qry_rs1   = 5'd5;
    qry_rs2   = 5'd0;
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    chk("pre_rst_busy5", 64'(busy_rs1), 1);
    chk("pre_rst_we", 64'(we), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 64'(we), 0);
    chk("mid_rst_ready", 64'(req_ready), 0);
    for (int q = 0; q < 32; q++) begin
      qry_rs1 = 5'(q);
      #1;
      chk($sformatf("mid_rst_busy_r%0d", q), 64'(busy_rs1), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b000;
    qry_rs1 = 5'd0;

    // Contending requesters, then hold and release
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      req_valid = s_vld[k];
      hold      = s_hld[k];
      #1;
      chk($sformatf("s%0d_ready", k), 64'(req_ready), 64'(s_rdy[k]));
      chk($sformatf("s%0d_we", k), 64'(we), 64'(s_we[k]));
      if (s_we[k])
        chk($sformatf("s%0d_waddr", k), 64'(waddr), 64'(s_wa[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
